// File: rtl/tpu_pkg.sv
// Shared types and default sizing for the conv window sequencer slice.
// Pure declarations: no timing or backpressure of its own.
package tpu_pkg;

  localparam int DATA_SIZE    = 8;
  localparam int KERNEL_WIDTH = 3;
  localparam int NUM_REGISTER = 256;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    CAPTURE,
    PRESENT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Window/kernel position counters producing row-major buffer addresses with adders only.
// Zero latency from counters to rd_addr; only moves on step (fetch) or win_adv (accepted window).
module window_addr_gen
  import tpu_pkg::*;
#(
  parameter int K  = KERNEL_WIDTH,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          init,
  input  logic          step,
  input  logic          win_adv,
  input  logic [AW:0]   width,
  output logic [AW-1:0] rd_addr,
  output logic          fetch_last,
  output logic          win_last
);

  localparam int KW = $clog2(K + 1);
  localparam logic [KW-1:0] KMAX = KW'(K - 1);
  localparam logic [AW:0]   K_A  = (AW + 1)'(K);

  logic [KW-1:0] kx, ky;
  logic [AW:0]   ox, oy, base, row, ox_max;

  assign ox_max     = width - K_A;
  assign fetch_last = (kx == KMAX) && (ky == KMAX);
  assign win_last   = (ox == ox_max) && (oy == ox_max);
  assign rd_addr    = row[AW-1:0] + {{(AW - KW){1'b0}}, kx};

  // row tracks base + ky*W; base tracks oy*W + ox
  always_ff @(posedge clk) begin
    if (!nrst || init) begin
      kx   <= '0;
      ky   <= '0;
      ox   <= '0;
      oy   <= '0;
      base <= '0;
      row  <= '0;
    end else begin
      if (step) begin
        if (kx == KMAX) begin
          kx <= '0;
          if (ky == KMAX) begin
            ky  <= '0;
            row <= base;
          end else begin
            ky  <= ky + 1'b1;
            row <= row + width;
          end
        end else begin
          kx <= kx + 1'b1;
        end
      end
      if (win_adv) begin
        if (ox == ox_max) begin
          ox   <= '0;
          oy   <= oy + 1'b1;
          base <= base + K_A;
          row  <= base + K_A;
        end else begin
          ox   <= ox + 1'b1;
          base <= base + 1'b1;
          row  <= base + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every KxK window of a WxW ifmap, reads it from the activation buffer and presents it packed.
// K*K+2 cycles per window with win_ready held high; holds the window and stops reading while win_ready is low.
module conv_window_sequencer
  import tpu_pkg::*;
#(
  parameter int dataSize    = DATA_SIZE,
  parameter int kernelWidth = KERNEL_WIDTH,
  parameter int numRegister = NUM_REGISTER,
  localparam int AW  = $clog2(numRegister),
  localparam int NPE = kernelWidth * kernelWidth
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    ctrl_start,
  input  logic [15:0]             cfg_ifmap_width,
  output logic                    rd_en,
  output logic [AW-1:0]           rd_addr,
  input  logic [dataSize-1:0]     rd_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [NPE*dataSize-1:0] win_data,
  output logic                    win_last,
  output logic                    flag_busy,
  output logic                    flag_done,
  output logic                    flag_err
);

  seq_state_t  state;
  logic [15:0] w_q;
  logic [31:0] w_sq;
  logic        cfg_bad, rd_en_d, fetch_last, gen_win_last;

  assign w_sq    = {16'b0, w_q} * {16'b0, w_q};
  assign cfg_bad = (w_q < 16'(kernelWidth)) || (w_sq > 32'(numRegister));

  window_addr_gen #(.K(kernelWidth), .AW(AW)) u_addr (
    .clk        (clk),
    .nrst       (nrst),
    .init       ((state == IDLE) && ctrl_start),
    .step       (state == FETCH),
    .win_adv    ((state == PRESENT) && win_ready),
    .width      (w_q[AW:0]),
    .rd_addr    (rd_addr),
    .fetch_last (fetch_last),
    .win_last   (gen_win_last)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      w_q       <= '0;
      rd_en     <= 1'b0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      flag_busy <= 1'b0;
      flag_done <= 1'b0;
      flag_err  <= 1'b0;
    end else begin
      flag_done <= 1'b0;
      unique case (state)
        IDLE: if (ctrl_start) begin
          w_q       <= cfg_ifmap_width;
          flag_busy <= 1'b1;
          flag_err  <= 1'b0;
          state     <= CHECK;
        end
        CHECK: if (cfg_bad) begin
          flag_err  <= 1'b1;
          flag_done <= 1'b1;
          flag_busy <= 1'b0;
          state     <= DONE;
        end else begin
          rd_en <= 1'b1;
          state <= FETCH;
        end
        FETCH: if (fetch_last) begin
          rd_en <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          win_valid <= 1'b1;
          win_last  <= gen_win_last;
          state     <= PRESENT;
        end
        PRESENT: if (win_ready) begin
          win_valid <= 1'b0;
          win_last  <= 1'b0;
          if (win_last) begin
            flag_done <= 1'b1;
            flag_busy <= 1'b0;
            state     <= DONE;
          end else begin
            rd_en <= 1'b1;
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lands one cycle after rd_en; shifting in at the top leaves element 0 at the bottom.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_en_d  <= 1'b0;
      win_data <= '0;
    end else begin
      rd_en_d <= rd_en;
      if (rd_en_d) win_data <= {rd_data, win_data[NPE*dataSize-1:dataSize]};
    end
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: table of frames plus randomized frames, checked against a window model.
module tb_conv_window_sequencer;
  import tpu_pkg::*;

  localparam int DS  = 8;
  localparam int K   = 3;
  localparam int NR  = 256;
  localparam int AW  = 8;
  localparam int NPE = K * K;

  logic                clk = 1'b0;
  logic                nrst, ctrl_start, win_ready;
  logic [15:0]         cfg;
  logic                rd_en, win_valid, win_last, flag_busy, flag_done, flag_err;
  logic [AW-1:0]       rd_addr;
  logic [DS-1:0]       rd_data;
  logic [NPE*DS-1:0]   win_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [NR];

  conv_window_sequencer dut (
    .clk             (clk),
    .nrst            (nrst),
    .ctrl_start      (ctrl_start),
    .cfg_ifmap_width (cfg),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .win_valid       (win_valid),
    .win_ready       (win_ready),
    .win_data        (win_data),
    .win_last        (win_last),
    .flag_busy       (flag_busy),
    .flag_done       (flag_done),
    .flag_err        (flag_err)
  );

  always #5 clk = ~clk;

  // Buffer model: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Window idx in raster order: element ky*K+kx is pixel (oy+ky, ox+kx).
  function automatic logic [NPE*DS-1:0] model_win(input int w, input int idx);
    logic [NPE*DS-1:0] r;
    int n, ox, oy;
    r = '0;
    if (w < K) return r;
    n  = w - K + 1;
    ox = idx % n;
    oy = idx / n;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        r[(ky*K + kx)*DS +: DS] = mem[(oy + ky)*w + ox + kx];
    return r;
  endfunction

  task automatic run_frame(input string tag, input int w, input bit thr, input int repulse,
                           input bit exp_err, input int exp_nwin, input int exp_done,
                           input bit chk_ends, input logic [71:0] exp_first, input logic [71:0] exp_last);
    int cnt = 0, nwin = 0, nrd = 0, done_cyc = -1, first_rd = -1, first_vld = -1;
    int busy_bad = 0, ovl_bad = 0, stab_bad = 0, data_bad = 0, last_bad = 0, addr_bad = 0;
    bit done = 0, stalled = 0, held_last = 0, err_at_done = 0, err_start = 0;
    logic [71:0] held = '0, first_dat = '0, last_dat = '0, exp_w;
    @(negedge clk);
    ctrl_start = 1'b1;
    cfg        = 16'(w);
    win_ready  = 1'b1;
    while (!done && cnt < 6000) begin
      @(negedge clk);
      cnt++;
      ctrl_start = (cnt == repulse);
      cfg        = (cnt == repulse) ? 16'd4 : 16'($urandom_range(0, 40));
      if (cnt == 1) err_start = flag_err;
      if (rd_en) begin
        nrd++;
        if (first_rd < 0) first_rd = cnt;
        if (int'(rd_addr) >= w*w) addr_bad++;
      end
      if (win_valid && rd_en) ovl_bad++;
      if (stalled && (!win_valid || win_data !== held || win_last !== held_last)) stab_bad++;
      if (win_valid && first_vld < 0) first_vld = cnt;
      if (flag_done) begin
        done = 1;
        done_cyc = cnt;
        err_at_done = flag_err;
        if (flag_busy) busy_bad++;
      end else if (flag_busy !== 1'b1) busy_bad++;
      win_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (win_valid) begin
        if (win_ready) begin
          exp_w = model_win(w, nwin);
          if (win_data !== exp_w) begin
            if (data_bad == 0) chk({tag, " win_data"}, win_data, exp_w);
            data_bad++;
          end
          if (win_last !== (nwin == exp_nwin - 1)) last_bad++;
          if (nwin == 0) first_dat = win_data;
          last_dat = win_data;
          nwin++;
        end else begin
          stalled   = 1;
          held      = win_data;
          held_last = win_last;
        end
      end
    end
    ctrl_start = 1'b0;
    chk({tag, " done_seen"}, done, 1'b1);
    @(negedge clk);
    chk({tag, " done_pulse_busy_after"}, {flag_done, flag_busy, win_valid}, 3'b000);
    chk({tag, " windows"}, nwin, exp_nwin);
    chk({tag, " reads"}, nrd, exp_nwin * NPE);
    chk({tag, " err_at_done"}, err_at_done, exp_err);
    chk({tag, " err_cleared_on_start"}, err_start, 1'b0);
    chk({tag, " busy_bad_cycles"}, busy_bad, 0);
    chk({tag, " read_during_present"}, ovl_bad, 0);
    chk({tag, " stall_unstable"}, stab_bad, 0);
    chk({tag, " data_bad_windows"}, data_bad, 0);
    chk({tag, " last_flag_bad"}, last_bad, 0);
    chk({tag, " addr_out_of_frame"}, addr_bad, 0);
    if (exp_done >= 0) chk({tag, " done_cycle"}, done_cyc, exp_done);
    if (!exp_err && !thr) begin
      chk({tag, " first_rd_cycle"}, first_rd, 2);
      chk({tag, " first_valid_cycle"}, first_vld, 2 + NPE + 1);
    end
    if (chk_ends) begin
      chk({tag, " first_window"}, first_dat, exp_first);
      chk({tag, " last_window"}, last_dat, exp_last);
    end
  endtask

  typedef struct {
    string       tag;
    int          w;
    bit          thr;
    int          repulse;
    bit          exp_err;
    int          exp_nwin;
    int          exp_done;
    bit          chk_ends;
    logic [71:0] first;
    logic [71:0] last;
  } vec_t;

  localparam logic [71:0] W5_FIRST = 72'h0C0B0A_070605_020100;
  localparam logic [71:0] W5_LAST  = 72'h181716_131211_0E0D0C;

  initial begin
    vec_t vecs[$];
    int   w, nwin;
    bit   thr, err;

    nrst = 1'b0; ctrl_start = 1'b0; cfg = '0; win_ready = 1'b0;
    for (int i = 0; i < NR; i++) mem[i] = 8'(i);

    vecs.push_back('{"w5",        5,  0, 0,  0, 9,   101,  1, W5_FIRST, W5_LAST});
    vecs.push_back('{"w5_thr",    5,  1, 0,  0, 9,   -1,   1, W5_FIRST, W5_LAST});
    vecs.push_back('{"w2_err",    2,  0, 0,  1, 0,   2,    0, '0, '0});
    vecs.push_back('{"w3_one",    3,  0, 0,  0, 1,   13,   0, '0, '0});
    vecs.push_back('{"w16",       16, 0, 0,  0, 196, 2158, 0, '0, '0});
    vecs.push_back('{"w17_err",   17, 0, 0,  1, 0,   2,    0, '0, '0});
    vecs.push_back('{"w5_repuls", 5,  0, 20, 0, 9,   101,  1, W5_FIRST, W5_LAST});
    vecs.push_back('{"w4_thr",    4,  1, 0,  0, 4,   -1,   0, '0, '0});
    vecs.push_back('{"w0_err",    0,  0, 0,  1, 0,   2,    0, '0, '0});

    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_en, rd_addr, win_valid, win_data, win_last, flag_busy, flag_done, flag_err}, '0);
    nrst = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_frame(vecs[i].tag, vecs[i].w, vecs[i].thr, vecs[i].repulse, vecs[i].exp_err,
                vecs[i].exp_nwin, vecs[i].exp_done, vecs[i].chk_ends, vecs[i].first, vecs[i].last);

    // Reset in the middle of a fetch, then a clean frame.
    @(negedge clk);
    ctrl_start = 1'b1; cfg = 16'd5;
    @(negedge clk);
    ctrl_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_in_fetch", {rd_en, flag_busy}, 2'b11);
    nrst = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {rd_en, rd_addr, win_valid, win_data, win_last, flag_busy, flag_done, flag_err}, '0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_no_done", {flag_done, flag_busy}, 2'b00);
    run_frame("after_reset", 5, 0, 0, 0, 9, 101, 1, W5_FIRST, W5_LAST);

    // Randomized frames over random buffer contents.
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < NR; i++) mem[i] = 8'($urandom);
      w    = $urandom_range(0, 18);
      thr  = 1'($urandom_range(0, 1));
      err  = (w < K) || (w * w > NR);
      nwin = err ? 0 : (w - K + 1) * (w - K + 1);
      run_frame($sformatf("rand%0d_w%0d", it, w), w, thr, 0, err, nwin,
                thr ? -1 : (err ? 2 : 2 + (NPE + 2) * nwin), 0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
